// File: rtl/pc_unit.sv
// Next-PC and status-flag stage of the single-cycle MIPS core: selects the next PC,
// holds the Z/N flags and the retired-instruction count, and traps misaligned targets.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [31:0]      instruction,
  input  logic             is_jump,
  input  logic             zero_branch,
  input  logic             need_zero,
  input  logic             status_branch,
  input  logic             need_st_Z,
  input  logic [1:0]       pc_select,
  input  logic             link,
  input  logic             alu_zero,
  input  logic [31:0]      alu_result,
  input  logic             flag_update,
  input  logic [31:0]      reg_rs,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [31:0]      link_addr,
  output logic             branch_taken,
  output logic             st_Z,
  output logic             st_N,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    SEL_PC_REL = 2'b00,
    SEL_PSEUDO = 2'b01,
    SEL_REG    = 2'b10,
    SEL_MEM    = 2'b11
  } pc_sel_e;

  logic [31:0]      pc_q, pc_d;
  logic             st_z_q, st_z_d;
  logic             st_n_q, st_n_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [15:0] imm;
  logic [25:0] jtarget;
  logic [31:0] branch_off;
  logic [31:0] target;
  logic        zero_taken;
  logic        status_taken;
  logic        misalign;
  logic        advance;

  assign imm        = instruction[15:0];
  assign jtarget    = instruction[25:0];
  assign branch_off = {{14{imm[15]}}, imm, 2'b00};
  assign pc_plus4   = pc_q + 32'd4;
  assign link_addr  = link ? pc_plus4 : 32'd0;

  // NOTE: every always_comb output is given a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    target = pc_plus4 + branch_off;
    unique case (pc_sel_e'(pc_select))
      SEL_PC_REL: target = pc_plus4 + branch_off;
      SEL_PSEUDO: target = {pc_plus4[31:28], jtarget, 2'b00};
      SEL_REG:    target = reg_rs;
      SEL_MEM:    target = mem_rdata;
      default:    target = pc_plus4 + branch_off;
    endcase
  end

  // Status branches read the registered flags, so a same-cycle flag_update is not seen.
  assign zero_taken   = zero_branch & (alu_zero == need_zero);
  assign status_taken = status_branch & (need_st_Z ? st_z_q : st_n_q);
  assign branch_taken = is_jump | zero_taken | status_taken;
  assign misalign     = branch_taken & (target[1:0] != 2'b00);
  assign advance      = ~stall & ~fault_q;

  always_comb begin
    pc_d      = pc_q;
    st_z_d    = st_z_q;
    st_n_d    = st_n_q;
    fault_d   = fault_q;
    retired_d = retired_q;
    if (advance) begin
      if (misalign) begin
        fault_d = 1'b1;
      end else begin
        pc_d      = branch_taken ? target : pc_plus4;
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (flag_update) begin
        st_z_d = (alu_result == 32'd0);
        st_n_d = alu_result[31];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      st_z_q    <= 1'b0;
      st_n_q    <= 1'b0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      pc_q      <= pc_d;
      st_z_q    <= st_z_d;
      st_n_q    <= st_n_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  assign pc      = pc_q;
  assign st_Z    = st_z_q;
  assign st_N    = st_n_q;
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios plus random cycles, checked against
// an architectural model of PC, flags, fault and retired count.
module tb_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             stall = 1'b0;
  logic [31:0]      instruction = '0;
  logic             is_jump = 1'b0, zero_branch = 1'b0, need_zero = 1'b0;
  logic             status_branch = 1'b0, need_st_Z = 1'b0;
  logic [1:0]       pc_select = 2'b00;
  logic             link = 1'b0, alu_zero = 1'b0, flag_update = 1'b0;
  logic [31:0]      alu_result = '0, reg_rs = '0, mem_rdata = '0;
  logic [31:0]      pc, pc_plus4, link_addr;
  logic             branch_taken, st_Z, st_N, fault;
  logic [CNT_W-1:0] retired;

  pc_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .instruction(instruction),
    .is_jump(is_jump), .zero_branch(zero_branch), .need_zero(need_zero),
    .status_branch(status_branch), .need_st_Z(need_st_Z), .pc_select(pc_select),
    .link(link), .alu_zero(alu_zero), .alu_result(alu_result),
    .flag_update(flag_update), .reg_rs(reg_rs), .mem_rdata(mem_rdata),
    .pc(pc), .pc_plus4(pc_plus4), .link_addr(link_addr),
    .branch_taken(branch_taken), .st_Z(st_Z), .st_N(st_N), .fault(fault),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [31:0] instr;
    logic        is_jump, zero_branch, need_zero, status_branch, need_st_z;
    logic [1:0]  sel;
    logic        link, alu_zero, flag_update;
    logic [31:0] alu_result, reg_rs, mem_rdata;
  } stim_t;

  typedef struct {
    logic [31:0] pc, pc_plus4, link_addr;
    logic        taken, z, n, fault;
    int unsigned retired;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  // Architectural model state
  logic [31:0] m_pc;
  logic        m_z, m_n, m_fault;
  int unsigned m_ret;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{stall: 1'b0, instr: 32'd0, is_jump: 1'b0, zero_branch: 1'b0, need_zero: 1'b0,
          status_branch: 1'b0, need_st_z: 1'b0, sel: 2'b00, link: 1'b0, alu_zero: 1'b0,
          flag_update: 1'b0, alu_result: 32'd0, reg_rs: 32'd0, mem_rdata: 32'd0};
    return s;
  endfunction

  function automatic stim_t jump(input logic [1:0] sel, input logic [31:0] dest);
    stim_t s;
    s = idle();
    s.is_jump = 1'b1;
    s.sel = sel;
    s.reg_rs = dest;
    s.mem_rdata = dest;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    stall = s.stall; instruction = s.instr; is_jump = s.is_jump;
    zero_branch = s.zero_branch; need_zero = s.need_zero;
    status_branch = s.status_branch; need_st_Z = s.need_st_z; pc_select = s.sel;
    link = s.link; alu_zero = s.alu_zero; flag_update = s.flag_update;
    alu_result = s.alu_result; reg_rs = s.reg_rs; mem_rdata = s.mem_rdata;
  endtask

  // One instruction cycle: drive after the edge, record expectations, then advance the model.
  task automatic cycle(input stim_t s);
    exp_t        e;
    logic [31:0] p4, tgt, off;
    logic        taken;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(s);
    p4  = m_pc + 32'd4;
    off = {{16{s.instr[15]}}, s.instr[15:0]} * 32'd4;
    case (s.sel)
      2'b00:   tgt = p4 + off;
      2'b01:   tgt = {p4[31:28], s.instr[25:0], 2'b00};
      2'b10:   tgt = s.reg_rs;
      default: tgt = s.mem_rdata;
    endcase
    taken = s.is_jump || (s.zero_branch && (s.alu_zero == s.need_zero)) ||
            (s.status_branch && (s.need_st_z ? m_z : m_n));
    e = '{pc: m_pc, pc_plus4: p4, link_addr: s.link ? p4 : 32'd0, taken: taken,
          z: m_z, n: m_n, fault: m_fault, retired: m_ret};
    exp_q.push_back(e);
    if (!s.stall && !m_fault) begin
      if (taken && tgt[1:0] != 2'b00) begin
        m_fault = 1'b1;
      end else begin
        m_pc  = taken ? tgt : p4;
        m_ret = (m_ret + 1) % (1 << CNT_W);
      end
      if (s.flag_update) begin
        m_z = (s.alu_result == 32'd0);
        m_n = s.alu_result[31];
      end
    end
  endtask

  // Reset asserted between edges; outputs are checked before the next rising edge.
  task automatic reset_pulse();
    exp_t e;
    @(posedge clk);
    #1;
    apply(idle());
    rst_n = 1'b0;
    m_pc = RESET_PC; m_z = 1'b0; m_n = 1'b0; m_fault = 1'b0; m_ret = 0;
    e = '{pc: RESET_PC, pc_plus4: RESET_PC + 32'd4, link_addr: 32'd0, taken: 1'b0,
          z: 1'b0, n: 1'b0, fault: 1'b0, retired: 0};
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents its outputs; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", pc, e.pc);
        check("pc_plus4", pc_plus4, e.pc_plus4);
        check("link_addr", link_addr, e.link_addr);
        check("branch_taken", {31'd0, branch_taken}, {31'd0, e.taken});
        check("st_Z", {31'd0, st_Z}, {31'd0, e.z});
        check("st_N", {31'd0, st_N}, {31'd0, e.n});
        check("fault", {31'd0, fault}, {31'd0, e.fault});
        check("retired", {{(32-CNT_W){1'b0}}, retired}, e.retired);
      end
    end
  end

  initial begin
    stim_t s;
    int    drain;
    // 1: reset then straight-line code
    reset_pulse();
    repeat (4) cycle(idle());

    // 2: PC-relative branch on zero, taken then not taken
    cycle(jump(2'b10, 32'h100));
    s = idle(); s.zero_branch = 1'b1; s.need_zero = 1'b1; s.alu_zero = 1'b1;
    s.instr = 32'h0000_FFFE; s.link = 1'b1;
    cycle(s);
    s.alu_zero = 1'b0;
    cycle(s);

    // 3: status branch uses flags from an earlier cycle only
    s = idle(); s.flag_update = 1'b1; s.alu_result = 32'h8000_0000;
    cycle(s);
    s = idle(); s.status_branch = 1'b1; s.need_st_z = 1'b0; s.sel = 2'b01;
    s.instr = 32'h0000_0010;
    cycle(s);
    s.flag_update = 1'b1; s.alu_result = 32'h0000_0001;
    cycle(s);
    cycle(s);
    cycle(idle());

    // 4: misaligned register jump traps and freezes state
    cycle(jump(2'b10, 32'h200));
    cycle(jump(2'b10, 32'h1002));
    cycle(jump(2'b10, 32'h400));
    cycle(jump(2'b11, 32'h800));
    cycle(idle());
    reset_pulse();
    cycle(idle());

    // 5: stalled memory-indirect jump
    s = jump(2'b11, 32'h3000); s.stall = 1'b1;
    repeat (4) cycle(s);
    s.stall = 1'b0;
    cycle(s);
    cycle(idle());

    // 6: PC wrap, retired wrap, mid-cycle reset
    cycle(jump(2'b10, 32'hFFFF_FFFC));
    cycle(idle());
    cycle(idle());
    repeat ((1 << CNT_W) + 3) cycle(idle());
    reset_pulse();

    // Random cycles
    for (int i = 0; i < 3000; i++) begin
      if (m_fault && $urandom_range(0, 7) == 0) begin
        reset_pulse();
      end else begin
        s.stall         = ($urandom_range(0, 7) == 0);
        s.instr         = $urandom;
        s.is_jump       = ($urandom_range(0, 5) == 0);
        s.zero_branch   = $urandom_range(0, 1);
        s.need_zero     = $urandom_range(0, 1);
        s.status_branch = $urandom_range(0, 1);
        s.need_st_z     = $urandom_range(0, 1);
        s.sel           = 2'($urandom_range(0, 3));
        s.link          = $urandom_range(0, 1);
        s.alu_zero      = $urandom_range(0, 1);
        s.flag_update   = $urandom_range(0, 1);
        s.alu_result    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        s.reg_rs        = $urandom & 32'hFFFF_FFFC;
        s.mem_rdata     = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 39) == 0) s.reg_rs[1:0] = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 39) == 0) s.mem_rdata[1:0] = 2'($urandom_range(1, 3));
        cycle(s);
      end
    end

    // Bounded drain of the scoreboard
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Next-PC and status-flag stage sitting directly downstream of the instruction decoder in the single-cycle MIPS core.
- Consumes the decoder's branch/jump controls together with ALU, register-file and data-memory results.
- Holds the architectural PC, the Z/N status register and a retired-instruction counter.
- Resolves taken/not-taken each cycle, produces the link address and traps misaligned control-flow targets.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold all state this cycle
instruction  in  32  current instruction (imm = [15:0], target = [25:0])
is_jump  in  1  unconditional control transfer
zero_branch  in  1  branch on ALU zero
need_zero  in  1  1: taken when alu_zero=1; 0: taken when alu_zero=0
status_branch  in  1  branch on status flag
need_st_Z  in  1  1: test st_Z; 0: test st_N
pc_select  in  2  target source: 00 PC-relative, 01 pseudo-direct, 10 register, 11 memory
link  in  1  instruction links (informational; qualifies link_addr)
alu_zero  in  1  ALU result == 0
alu_result  in  32  ALU result
flag_update  in  1  load Z/N from alu_result at end of cycle
reg_rs  in  32  rs register value
mem_rdata  in  32  data-memory read data
pc  out  32  current PC (registered)
pc_plus4  out  32  pc + 4, combinational
link_addr  out  32  pc_plus4 when link=1, else 0
branch_taken  out  1  combinational taken decision
st_Z  out  1  registered zero flag
st_N  out  1  registered negative flag
fault  out  1  sticky misaligned-target trap
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, st_Z=0, st_N=0, fault=0, retired=0. Takes effect immediately, including mid-instruction. First edge after release executes the instruction at RESET_PC.
- Targets:
  - 00: pc_plus4 + (sign_ext(imm) << 2)
  - 01: {pc_plus4[31:28], target, 2'b00}
  - 10: reg_rs
  - 11: mem_rdata
- branch_taken = is_jump | (zero_branch & (alu_zero == need_zero)) | (status_branch & (need_st_Z ? st_Z : st_N)).
- Status branches use the registered flags, i.e. the flags from the most recent earlier flag_update.
- If flag_update and status_branch are asserted in the same cycle, the branch tests the old flags and the flags then update.
- misalign = branch_taken & (target[1:0] != 0).
  - Not possible for pc_select 00/01.
  - Checked for 10/11.
- Each rising edge with stall=0 and fault=0:
  - pc <= branch_taken ? target : pc_plus4, unless misalign.
  - If misalign: pc holds and fault <= 1.
  - If flag_update: st_Z <= (alu_result==0), st_N <= alu_result[31].
  - retired increments by 1, except on the misalign cycle.
- stall=1: pc, flags, fault and retired all hold. Combinational outputs still track their inputs.
- fault=1: all state frozen until reset; only rst_n clears fault.
- Arithmetic: pc_plus4 and the branch adder wrap modulo 2^32. retired wraps to 0 after all-ones.
- Latency: branch_taken and target are combinational in the same cycle; the new pc is visible one edge later.
- link_addr is always pc_plus4 of the linking instruction, regardless of taken/not-taken. The decoder's reg_write/write_reg31 decide whether it is stored.

Test Plan:
1. Reset with RESET_PC=0, then 3 cycles of no control-flow → pc = 0,4,8,12; retired = 3; link_addr = 0 throughout.
2. pc=0x100, zero_branch=1, need_zero=1, alu_zero=1, imm=16'hFFFE, pc_select=00 → next pc = 0xFC; then alu_zero=0 → next pc = 0x100.
3. Cycle A: flag_update=1, alu_result=0x8000_0000. Cycle B: status_branch=1, need_st_Z=0, pc=0x40, pc_select=01, target=26'h10 → st_N=1, st_Z=0 after A; B jumps to 0x40. Repeat with flag_update set in B itself → B still uses A's flags.
4. pc=0x200, is_jump=1, pc_select=10, reg_rs=0x1002 → fault=1, pc stays 0x200, retired unchanged; subsequent legal jumps are ignored until rst_n pulse.
5. stall=1 for 4 cycles during a taken jump (pc_select=11, mem_rdata=0x3000) → pc and retired hold. Deassert stall → pc = 0x3000 on the next edge.
6. pc=0xFFFF_FFFC, no branch → pc wraps to 0x0. Separately, force retired to all-ones, then advance one instruction → retired = 0. Assert rst_n low between edges → pc = RESET_PC immediately.
